// File: rtl/hdmi_pkg.sv
// Shared constants and types for the TMDS serializer: symbol width, idle and
// clock-lane patterns, FSM states and the RGB symbol triple.
package hdmi_pkg;
  localparam int SYM_W = 10;
  localparam logic [SYM_W-1:0] IDLE_SYM    = 10'b1101010100;
  // Sent LSB first, so the clock lane reads 1111100000 on the wire.
  localparam logic [SYM_W-1:0] CLK_PATTERN = 10'b0000011111;
  localparam logic [3:0]       LAST_PHASE  = 4'd9;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  typedef struct packed {
    logic [SYM_W-1:0] red;
    logic [SYM_W-1:0] grn;
    logic [SYM_W-1:0] blu;
  } sym_triple_t;
endpackage

// File: rtl/tmds_shift_lane.sv
// One serial lane: a 10-bit register that loads a symbol or shifts right,
// presenting bit 0 on the serial output.
module tmds_shift_lane
  import hdmi_pkg::*;
#(
  parameter logic [SYM_W-1:0] RESET_VAL = IDLE_SYM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SYM_W-1:0] load_val,
  output logic             ser
);

  logic [SYM_W-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sr <= RESET_VAL;
    else if (load) sr <= load_val;
    else           sr <= {1'b0, sr[SYM_W-1:1]};
  end

  assign ser = sr[0];

endmodule

// File: rtl/tmds_serializer.sv
// TMDS serializer: one-deep holding register feeding three data lanes and a
// clock lane, with idle-symbol insertion and a sticky underflow flag.
module tmds_serializer
  import hdmi_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sym_valid,
  output logic             o_sym_ready,
  input  logic [SYM_W-1:0] i_sym_red,
  input  logic [SYM_W-1:0] i_sym_grn,
  input  logic [SYM_W-1:0] i_sym_blu,
  output logic             o_ser_red,
  output logic             o_ser_grn,
  output logic             o_ser_blu,
  output logic             o_ser_clk,
  output logic [3:0]       o_bit_phase,
  output logic             o_underflow,
  input  logic             i_clr_underflow
);

  logic [3:0]  phase;
  logic        load;
  logic        accept;
  logic        hold_full;
  sym_triple_t hold;
  sym_triple_t next_sym;
  state_t      state;
  state_t      state_nxt;
  logic        uf_set;

  assign load        = (phase == LAST_PHASE);
  assign o_sym_ready = !hold_full;
  assign accept      = i_sym_valid && o_sym_ready;
  assign o_bit_phase = phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       phase <= '0;
    else if (load) phase <= '0;
    else           phase <= phase + 4'd1;
  end

  // Accept only happens while empty, so accept-on-load refills and stays full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         hold_full <= 1'b0;
    else if (accept) hold_full <= 1'b1;
    else if (load)   hold_full <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) hold <= '{red: i_sym_red, grn: i_sym_grn, blu: i_sym_blu};
  end

  assign next_sym = hold_full ? hold : {IDLE_SYM, IDLE_SYM, IDLE_SYM};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_IDLE && load && hold_full) state_nxt = S_RUN;
  end

  always_comb begin
    uf_set = 1'b0;
    if (state == S_RUN && load && !hold_full) uf_set = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  o_underflow <= 1'b0;
    else if (uf_set)          o_underflow <= 1'b1;
    else if (i_clr_underflow) o_underflow <= 1'b0;
  end

  tmds_shift_lane #(.RESET_VAL(IDLE_SYM)) u_lane_red (
    .clk(clk), .rst(rst), .load(load), .load_val(next_sym.red), .ser(o_ser_red)
  );
  tmds_shift_lane #(.RESET_VAL(IDLE_SYM)) u_lane_grn (
    .clk(clk), .rst(rst), .load(load), .load_val(next_sym.grn), .ser(o_ser_grn)
  );
  tmds_shift_lane #(.RESET_VAL(IDLE_SYM)) u_lane_blu (
    .clk(clk), .rst(rst), .load(load), .load_val(next_sym.blu), .ser(o_ser_blu)
  );
  tmds_shift_lane #(.RESET_VAL(CLK_PATTERN)) u_lane_clk (
    .clk(clk), .rst(rst), .load(load), .load_val(CLK_PATTERN), .ser(o_ser_clk)
  );

endmodule

// File: tb/tb_tmds_serializer.sv
// Bench for tmds_serializer: directed steps plus random traffic, checked
// against a symbol-level model (one-deep queue, current symbol indexed by phase).
module tb_tmds_serializer;

  localparam logic [9:0] IDLE = 10'b1101010100;

  logic       clk;
  logic       rst;
  logic       i_sym_valid;
  logic       o_sym_ready;
  logic [9:0] i_sym_red, i_sym_grn, i_sym_blu;
  logic       o_ser_red, o_ser_grn, o_ser_blu, o_ser_clk;
  logic [3:0] o_bit_phase;
  logic       o_underflow;
  logic       i_clr_underflow;

  int n_checks = 0;
  int n_errors = 0;

  int          m_phase;
  logic [29:0] m_q[$];
  logic [29:0] m_cur;
  bit          m_run;
  bit          m_uf;

  tmds_serializer dut (
    .clk(clk), .rst(rst), .i_sym_valid(i_sym_valid), .o_sym_ready(o_sym_ready),
    .i_sym_red(i_sym_red), .i_sym_grn(i_sym_grn), .i_sym_blu(i_sym_blu),
    .o_ser_red(o_ser_red), .o_ser_grn(o_ser_grn), .o_ser_blu(o_ser_blu),
    .o_ser_clk(o_ser_clk), .o_bit_phase(o_bit_phase), .o_underflow(o_underflow),
    .i_clr_underflow(i_clr_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic bit_of(input logic [9:0] s, input int i);
    return s[i];
  endfunction

  task automatic check_all();
    chk("red",   32'(o_ser_red),   32'(bit_of(m_cur[29:20], m_phase)));
    chk("grn",   32'(o_ser_grn),   32'(bit_of(m_cur[19:10], m_phase)));
    chk("blu",   32'(o_ser_blu),   32'(bit_of(m_cur[9:0],   m_phase)));
    chk("sclk",  32'(o_ser_clk),   32'(m_phase < 5));
    chk("phase", 32'(o_bit_phase), 32'(m_phase));
    chk("ready", 32'(o_sym_ready), 32'(m_q.size() == 0));
    chk("uf",    32'(o_underflow), 32'(m_uf));
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_q.delete();
    m_cur = {IDLE, IDLE, IDLE};
    m_run = 0;
    m_uf  = 0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_sclk"},  32'(o_ser_clk),   32'd1);
    chk({tag, "_red"},   32'(o_ser_red),   32'd0);
    chk({tag, "_grn"},   32'(o_ser_grn),   32'd0);
    chk({tag, "_blu"},   32'(o_ser_blu),   32'd0);
    chk({tag, "_ready"}, 32'(o_sym_ready), 32'd1);
    chk({tag, "_phase"}, 32'(o_bit_phase), 32'd0);
    chk({tag, "_uf"},    32'(o_underflow), 32'd0);
  endtask

  // One clock: advance the model with the current inputs, then compare.
  task automatic tick(output bit acc);
    bit uf_set;
    uf_set = 0;
    acc = i_sym_valid && (m_q.size() == 0);
    if (m_phase == 9) begin
      if (m_q.size() != 0) begin
        m_cur = m_q.pop_front();
        m_run = 1;
      end else begin
        m_cur = {IDLE, IDLE, IDLE};
        if (m_run) uf_set = 1;
      end
      m_phase = 0;
    end else begin
      m_phase++;
    end
    if (acc) m_q.push_back({i_sym_red, i_sym_grn, i_sym_blu});
    m_uf = uf_set ? 1'b1 : (i_clr_underflow ? 1'b0 : m_uf);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    bit a;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  task automatic run_to_phase(input int p);
    bit a;
    for (int i = 0; i < 12 && m_phase != p; i++) tick(a);
  endtask

  task automatic async_reset();
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk_reset_values("rst_mid");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all();
  endtask

  initial begin : stim
    bit          a;
    bit          exp_idle[10];
    logic [9:0]  old_red;
    int          accepted;
    int          cycles;

    exp_idle = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 1};
    rst = 1'b1;
    i_sym_valid = 1'b0;
    i_clr_underflow = 1'b0;
    i_sym_red = '0; i_sym_grn = '0; i_sym_blu = '0;
    model_reset();

    // Reset values and idle stream
    @(posedge clk); #1;
    chk_reset_values("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    check_all();
    for (int i = 0; i < 10; i++) begin
      chk("idle_bit", 32'(o_ser_red), 32'(exp_idle[i]));
      chk("idle_bit_blu", 32'(o_ser_blu), 32'(exp_idle[i]));
      if (i < 9) tick(a);
    end
    tick(a);

    // Single triple accepted at phase 3
    run_to_phase(3);
    i_sym_valid = 1'b1;
    i_sym_red = 10'h3FF; i_sym_grn = 10'h000; i_sym_blu = 10'h155;
    tick(a);
    i_sym_valid = 1'b0;
    chk("single_ready_low", 32'(o_sym_ready), 32'd0);
    run_to_phase(0);
    chk("single_red0", 32'(o_ser_red), 32'd1);
    chk("single_blu0", 32'(o_ser_blu), 32'd1);
    run(1);
    chk("single_blu1", 32'(o_ser_blu), 32'd0);
    run(9);

    // Underflow once running, then clear and set-wins-over-clear
    run(12);
    chk("uf_set", 32'(o_underflow), 32'd1);
    run_to_phase(4);
    i_clr_underflow = 1'b1;
    tick(a);
    i_clr_underflow = 1'b0;
    chk("uf_clr", 32'(o_underflow), 32'd0);
    run_to_phase(9);
    i_clr_underflow = 1'b1;
    tick(a);
    i_clr_underflow = 1'b0;
    chk("uf_set_wins", 32'(o_underflow), 32'd1);

    // Back-to-back: 50 incrementing symbols
    run_to_phase(0);
    i_sym_valid = 1'b1;
    i_clr_underflow = 1'b1;
    i_sym_red = 10'($urandom); i_sym_grn = 10'($urandom); i_sym_blu = 10'($urandom);
    accepted = 0;
    cycles = 0;
    while (accepted < 50 && cycles < 1000) begin
      tick(a);
      i_clr_underflow = 1'b0;
      cycles++;
      if (a) begin
        accepted++;
        i_sym_red++; i_sym_grn++; i_sym_blu++;
      end
    end
    i_sym_valid = 1'b0;
    chk("b2b_count", 32'(accepted), 32'd50);
    chk("b2b_uf", 32'(o_underflow), 32'd0);
    run(20);

    // Offer at phase 9 while full: old goes out, new one gets held
    i_clr_underflow = 1'b1;
    run_to_phase(2);
    i_clr_underflow = 1'b0;
    i_sym_valid = 1'b1;
    i_sym_red = 10'($urandom); i_sym_grn = 10'($urandom); i_sym_blu = 10'($urandom);
    old_red = i_sym_red;
    tick(a);
    chk("sim_acc_a", 32'(a), 32'd1);
    i_sym_red = ~old_red; i_sym_grn = 10'($urandom); i_sym_blu = 10'($urandom);
    run_to_phase(9);
    chk("sim_ready9", 32'(o_sym_ready), 32'd0);
    tick(a);
    chk("sim_red0", 32'(o_ser_red), 32'(old_red[0]));
    chk("sim_acc_b_at9", 32'(a), 32'd0);
    tick(a);
    chk("sim_acc_b", 32'(a), 32'd1);
    chk("sim_full", 32'(o_sym_ready), 32'd0);
    i_sym_valid = 1'b0;
    run(25);

    // Reset at phase 6 with holding full: held triple never sent
    run_to_phase(1);
    i_sym_valid = 1'b1;
    i_sym_red = 10'h3FF; i_sym_grn = 10'h3FF; i_sym_blu = 10'h3FF;
    tick(a);
    i_sym_valid = 1'b0;
    run_to_phase(6);
    chk("rst_mid_full", 32'(o_sym_ready), 32'd0);
    async_reset();
    run(25);
    chk("rst_mid_uf", 32'(o_underflow), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      i_sym_valid = ($urandom % 3) != 0;
      i_clr_underflow = ($urandom % 16) == 0;
      i_sym_red = 10'($urandom); i_sym_grn = 10'($urandom); i_sym_blu = 10'($urandom);
      tick(a);
    end
    i_sym_valid = 1'b0;
    i_clr_underflow = 1'b0;
    run(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
